// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_pkg
// Description : Shared definitions for the serial sequence transmitter and
//               the matching detector blocks.
//               - state_t: S_IDLE=0, S_SHIFT=1, S_GAP=2, S_DONE=3
//               - default widths for pattern, repetition and gap fields
// Revision    : 1.0 - initial release
// ============================================================================
package seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int DEF_W  = 8;
    localparam int DEF_RW = 8;
    localparam int DEF_GW = 4;

endpackage : seq_pkg
`default_nettype wire

// File: rtl/seq_piso.sv
`default_nettype none
// ============================================================================
// Module      : seq_piso
// Description : Loadable W-bit parallel-in / serial-out shift register.
//               The low len bits of pattern are aligned to the top of the
//               register on load, so msb presents pattern[len-1] first.
//               Zeros are shifted in, so once the last bit has gone out msb
//               reads 0 until the next load.
// Ports       : clk, rst  - clock, synchronous active-high reset
//               clr       - synchronous clear of the register
//               load      - load aligned pattern (priority over shift)
//               shift     - advance one bit towards msb
//               pattern   - parallel data
//               len       - valid pattern length, 0..W
//               msb       - current serial bit (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module seq_piso #(
    parameter int W  = 8,
    parameter int LW = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          load,
    input  logic          shift,
    input  logic [W-1:0]  pattern,
    input  logic [LW-1:0] len,
    output logic          msb
);

    localparam logic [LW-1:0] C_W = LW'(W);

    logic [W-1:0]  r_sr;
    logic [LW-1:0] w_sh;
    logic [W-1:0]  w_aligned;

    // Shifting left by W-len pushes the unused upper bits out of the
    // register and leaves zeros below the pattern; len=0 yields all zeros.
    assign w_sh      = C_W - len;
    assign w_aligned = pattern << w_sh;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_sr <= '0;
        end else if (load) begin
            r_sr <= w_aligned;
        end else if (shift) begin
            r_sr <= r_sr << 1;
        end
    end

    assign msb = r_sr[W-1];

endmodule : seq_piso
`default_nettype wire

// File: rtl/seq_pattern_tx.sv
`default_nettype none
// ============================================================================
// Module      : seq_pattern_tx
// Description : Serial bit-pattern transmitter. Sends the low len bits of a
//               latched pattern MSB-first on x, reps times, with gap idle
//               cycles between repetitions. start/busy/done handshake.
// Ports       : clk, rst         - clock, synchronous active-high reset
//               start            - job request (ignored while busy)
//               abort            - cancel running job, no done pulse
//               pattern/len/reps/gap - job fields, latched on start
//               x, valid         - serial data and its qualifier
//               busy             - job in SHIFT or GAP
//               done             - one-cycle completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int W  = DEF_W,
    parameter int LW = $clog2(W + 1),
    parameter int RW = DEF_RW,
    parameter int GW = DEF_GW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [W-1:0]  pattern,
    input  logic [LW-1:0] len,
    input  logic [RW-1:0] reps,
    input  logic [GW-1:0] gap,
    output logic          x,
    output logic          valid,
    output logic          busy,
    output logic          done
);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [W-1:0]  r_pat;
    logic [LW-1:0] r_len;
    logic [GW-1:0] r_gap;
    logic [LW-1:0] r_bit_cnt;   // bits still to send after the current one
    logic [RW-1:0] r_rep_cnt;   // repetitions left, including the current one
    logic [GW-1:0] r_gap_cnt;   // idle cycles left after the current one
    logic          r_valid;
    logic          r_busy;
    logic          r_done;

    logic          w_latch;
    logic          w_load;
    logic          w_shift;
    logic          w_clr;
    logic [LW-1:0] w_len_eff;
    logic [W-1:0]  w_ld_pat;
    logic [LW-1:0] w_ld_len;
    logic          w_rep_next;

    assign w_len_eff = (len > LW'(W)) ? LW'(W) : len;

    // A fresh job loads straight from the ports; repeats reload the copy.
    assign w_ld_pat = w_latch ? pattern   : r_pat;
    assign w_ld_len = w_latch ? w_len_eff : r_len;

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_clr       = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                w_state_nxt = S_IDLE;
                if (start) begin
                    w_latch = 1'b1;
                    if (w_len_eff != '0 && reps != '0) begin
                        w_state_nxt = S_SHIFT;
                        w_load      = 1'b1;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_SHIFT: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                    w_clr       = 1'b1;
                end else if (r_bit_cnt != '0) begin
                    w_shift = 1'b1;
                end else if (r_rep_cnt == RW'(1)) begin
                    w_state_nxt = S_DONE;
                    w_shift     = 1'b1;   // empties the register so x drops to 0
                end else if (r_gap == '0) begin
                    w_load = 1'b1;        // back-to-back repeat, no bubble
                end else begin
                    w_state_nxt = S_GAP;
                    w_shift     = 1'b1;
                end
            end
            S_GAP: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                    w_clr       = 1'b1;
                end else if (r_gap_cnt == '0) begin
                    w_state_nxt = S_SHIFT;
                    w_load      = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_clr       = 1'b1;
            end
        endcase
    end

    assign w_rep_next = (r_state == S_SHIFT) && !abort &&
                        (r_bit_cnt == '0) && (r_rep_cnt != RW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_pat     <= '0;
            r_len     <= '0;
            r_gap     <= '0;
            r_bit_cnt <= '0;
            r_rep_cnt <= '0;
            r_gap_cnt <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= (w_state_nxt == S_SHIFT);
            r_busy  <= (w_state_nxt == S_SHIFT) || (w_state_nxt == S_GAP);
            r_done  <= (w_state_nxt == S_DONE);

            if (w_latch) begin
                r_pat <= pattern;
                r_len <= w_len_eff;
                r_gap <= gap;
            end

            if (w_load) begin
                r_bit_cnt <= w_ld_len - LW'(1);
            end else if (w_shift && r_bit_cnt != '0) begin
                r_bit_cnt <= r_bit_cnt - LW'(1);
            end

            if (w_latch) begin
                r_rep_cnt <= reps;
            end else if (w_rep_next) begin
                r_rep_cnt <= r_rep_cnt - RW'(1);
            end

            // Entering GAP counts gap-1 down to 0, so gap cycles total and
            // the maximum field value never needs an extra counter bit.
            if (r_state == S_SHIFT && w_state_nxt == S_GAP) begin
                r_gap_cnt <= r_gap - GW'(1);
            end else if (r_state == S_GAP && r_gap_cnt != '0) begin
                r_gap_cnt <= r_gap_cnt - GW'(1);
            end
        end
    end

    seq_piso #(
        .W  (W),
        .LW (LW)
    ) u_piso (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_clr),
        .load    (w_load),
        .shift   (w_shift),
        .pattern (w_ld_pat),
        .len     (w_ld_len),
        .msb     (x)
    );

    assign valid = r_valid;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule : seq_pattern_tx
`default_nettype wire

// File: tb/tb_seq_pattern_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_pattern_tx
// Description : Self-checking bench for seq_pattern_tx: table of directed
//               jobs, hand-written corner sequences, and random jobs checked
//               against a cycle-stream model of the transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_pattern_tx;

    logic       clk = 1'b0;
    logic       rst, start, abort;
    logic [7:0] pattern;
    logic [3:0] len;
    logic [7:0] reps;
    logic [3:0] gap;
    logic       x, valid, busy, done;

    int checks   = 0;
    int failures = 0;

    seq_pattern_tx dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .pattern(pattern), .len(len), .reps(reps), .gap(gap),
        .x(x), .valid(valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  pat;
        logic [3:0]  len;
        logic [7:0]  reps;
        logic [3:0]  gap;
        logic [31:0] bits;
        int          nbits;
        int          done_at;
    } vec_t;

    vec_t       vecs[8];
    logic [3:0] exp_q[$];   // {x, valid, busy, done} per cycle

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic begin_job(input logic [7:0] p, input logic [3:0] l,
                             input logic [7:0] r, input logic [3:0] g);
        pattern = p; len = l; reps = r; gap = g; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Observes from the current cycle (k=1) until done or the bound expires.
    task automatic collect(output logic [63:0] bits, output int nbits,
                           output int done_at, output int perr, output int det);
        logic [2:0] h;
        h = 3'b000; bits = '0; nbits = 0; done_at = -1; perr = 0; det = 0;
        for (int k = 1; k <= 600; k++) begin
            h = {h[1:0], x};
            if (h == 3'b101) det++;
            if (valid) begin
                bits = {bits[62:0], x};
                nbits++;
            end
            if ((valid && !busy) || (done && busy) || (x && !valid)) perr++;
            if (done) begin
                done_at = k;
                break;
            end
            tick();
        end
    endtask

    // Expected output stream of one job, from the job rules alone.
    task automatic build_model(input logic [7:0] p, input int l, input int r, input int g);
        int le;
        exp_q.delete();
        le = (l > 8) ? 8 : l;
        if (le != 0 && r != 0) begin
            for (int rr = 0; rr < r; rr++) begin
                for (int b = le - 1; b >= 0; b--) exp_q.push_back({p[b], 3'b110});
                if (rr < r - 1)
                    for (int gg = 0; gg < g; gg++) exp_q.push_back(4'b0010);
            end
        end
        exp_q.push_back(4'b0001);
    endtask

    initial begin
        logic [63:0] bits;
        int          nbits, done_at, perr, det, errs, cnt;

        vecs[0] = '{8'h05, 4'd3,  8'd1, 4'd0,  32'h5,    3,  4};
        vecs[1] = '{8'h05, 4'd3,  8'd3, 4'd0,  32'h16D,  9,  10};
        vecs[2] = '{8'h05, 4'd3,  8'd2, 4'd2,  32'h2D,   6,  9};
        vecs[3] = '{8'hA5, 4'd8,  8'd1, 4'd0,  32'hA5,   8,  9};
        vecs[4] = '{8'hFF, 4'd0,  8'd5, 4'd1,  32'h0,    0,  1};
        vecs[5] = '{8'hFF, 4'd4,  8'd0, 4'd1,  32'h0,    0,  1};
        vecs[6] = '{8'h3C, 4'd12, 8'd1, 4'd0,  32'h3C,   8,  9};
        vecs[7] = '{8'hFF, 4'd1,  8'd2, 4'd15, 32'h3,    2,  18};

        rst = 1'b1; start = 1'b0; abort = 1'b0;
        pattern = '0; len = '0; reps = '0; gap = '0;
        tick(); tick();
        rst = 1'b0;
        check("reset_outputs", {x, valid, busy, done}, 4'b0000);
        tick();
        check("idle_outputs", {x, valid, busy, done}, 4'b0000);

        for (int i = 0; i < 8; i++) begin
            begin_job(vecs[i].pat, vecs[i].len, vecs[i].reps, vecs[i].gap);
            collect(bits, nbits, done_at, perr, det);
            check($sformatf("vec%0d_bits", i), bits, {32'h0, vecs[i].bits});
            check($sformatf("vec%0d_nbits", i), nbits, vecs[i].nbits);
            check($sformatf("vec%0d_done_at", i), done_at, vecs[i].done_at);
            check($sformatf("vec%0d_protocol", i), perr, 0);
            if (i == 0) check("det101_once", det, 1);
            tick();
            check($sformatf("vec%0d_back_idle", i), {x, valid, busy, done}, 4'b0000);
        end

        // Start during busy ignored; start on the done cycle chains a job.
        begin_job(8'hA5, 4'd8, 8'd1, 4'd0);
        bits = '0; nbits = 0; done_at = -1;
        for (int k = 1; k <= 40; k++) begin
            if (valid) begin bits = {bits[62:0], x}; nbits++; end
            if (done) begin done_at = k; break; end
            if (k == 3) begin
                pattern = 8'hFF; len = 4'd2; reps = 8'd9; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        check("busy_start_bits", bits, 64'hA5);
        check("busy_start_done_at", done_at, 9);
        begin_job(8'h05, 4'd3, 8'd1, 4'd0);
        check("chain_first_bit", {x, valid, busy, done}, 4'b1110);
        collect(bits, nbits, done_at, perr, det);
        check("chain_bits", bits, 64'h5);
        check("chain_done_at", done_at, 4);
        tick();

        // Abort at the second bit.
        begin_job(8'h05, 4'd3, 8'd2, 4'd0);
        tick();
        check("abort_second_bit", {x, valid, busy, done}, 4'b0110);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_outputs", {x, valid, busy, done}, 4'b0000);
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            if (done || valid || busy) cnt++;
            tick();
        end
        check("abort_no_done", cnt, 0);

        // Reset in the middle of a gap.
        begin_job(8'h05, 4'd3, 8'd2, 4'd3);
        tick(); tick(); tick();
        check("gap_state", {x, valid, busy, done}, 4'b0010);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_gap", {x, valid, busy, done}, 4'b0000);
        tick();
        check("rst_stays_idle", {x, valid, busy, done}, 4'b0000);

        // Maximum repetition count.
        begin_job(8'h01, 4'd1, 8'd255, 4'd0);
        collect(bits, nbits, done_at, perr, det);
        check("reps255_valid", nbits, 255);
        check("reps255_done_at", done_at, 256);
        check("reps255_protocol", perr, 0);
        tick();

        // Random jobs against the stream model, with inputs churning while busy.
        for (int j = 0; j < 40; j++) begin
            logic [7:0] p;
            int l, r, g;
            p = 8'($urandom);
            l = $urandom_range(0, 10);
            r = $urandom_range(0, 4);
            g = $urandom_range(0, 3);
            build_model(p, l, r, g);
            begin_job(p, 4'(l), 8'(r), 4'(g));
            errs = 0;
            for (int i = 0; i < exp_q.size(); i++) begin
                if ({x, valid, busy, done} !== exp_q[i]) errs++;
                pattern = 8'($urandom);
                len     = 4'($urandom);
                reps    = 8'($urandom);
                gap     = 4'($urandom);
                start   = exp_q[i][1] ? ($urandom_range(0, 3) == 0) : 1'b0;
                tick();
            end
            start = 1'b0;
            if ({x, valid, busy, done} !== 4'b0000) errs++;
            check($sformatf("rand%0d_p%0h_l%0d_r%0d_g%0d", j, p, l, r, g), errs, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_seq_pattern_tx
`default_nettype wire
